// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache with its miss-handling FSM.
// Define DCACHE_PERF_EN to add the hit_cnt_o / miss_cnt_o performance counters.
module dcache_ctrl #(
    parameter int INDEX_W = 4,
    parameter int LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = 32 - 5 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, REFILL_DONE} stateT;
    stateT state, stateNext;

    logic [TAG_W-1:0]   tagArr  [SETS];
    logic [LINE_W-1:0]  dataArr [SETS];
    logic [SETS-1:0]    validBits, dirtyBits;

    logic [2:0]         reqWord;
    logic [INDEX_W-1:0] reqIdx;
    logic [TAG_W-1:0]   reqTag;
    logic [1:0]         unusedAddr;
    logic [7:0]         wordOff;
    logic [LINE_W-1:0]  curLine;
    logic               hit, idleHit, idleMiss, refillAck;

    logic [INDEX_W-1:0] missIdx, missIdxNext;
    logic [TAG_W-1:0]   missTag, missTagNext;
    logic               memEnNext, memWrNext;
    logic [31:0]        memAddrNext;
    logic [LINE_W-1:0]  memDataNext;

    assign reqWord    = cpu_addr_i[4:2];
    assign reqIdx     = cpu_addr_i[5+INDEX_W-1:5];
    assign reqTag     = cpu_addr_i[31:5+INDEX_W];
    assign unusedAddr = cpu_addr_i[1:0];
    assign wordOff    = {reqWord, 5'b0};
    assign curLine    = dataArr[reqIdx];

    assign hit       = validBits[reqIdx] && (tagArr[reqIdx] == reqTag);
    assign idleHit   = (state == IDLE) && cpu_req_i && hit;
    assign idleMiss  = (state == IDLE) && cpu_req_i && !hit;
    assign refillAck = (state == REFILL) && mem_ack_i;

    // Stall and load data are forced quiet while reset is held, since the arrays are unknown.
    assign cpu_stall_o = !rst_i && ((state != IDLE) || idleMiss);
    assign cpu_data_o  = rst_i ? '0 : curLine[wordOff +: 32];

    always_comb begin
        stateNext   = state;
        memEnNext   = mem_enable_o;
        memWrNext   = mem_write_o;
        memAddrNext = mem_addr_o;
        memDataNext = mem_data_o;
        missIdxNext = missIdx;
        missTagNext = missTag;
        case (state)
            IDLE: begin
                if (idleMiss) begin
                    missIdxNext = reqIdx;
                    missTagNext = reqTag;
                    memEnNext   = 1'b1;
                    if (validBits[reqIdx] && dirtyBits[reqIdx]) begin
                        stateNext   = WRITEBACK;
                        memWrNext   = 1'b1;
                        memAddrNext = {tagArr[reqIdx], reqIdx, 5'b0};
                        memDataNext = curLine;
                    end else begin
                        stateNext   = REFILL;
                        memWrNext   = 1'b0;
                        memAddrNext = {reqTag, reqIdx, 5'b0};
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    stateNext   = REFILL;
                    memWrNext   = 1'b0;
                    memAddrNext = {missTag, missIdx, 5'b0};
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    stateNext = REFILL_DONE;
                    memEnNext = 1'b0;
                end
            end
            REFILL_DONE: stateNext = IDLE;
            default:     stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            validBits    <= '0;
            dirtyBits    <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            missIdx      <= '0;
            missTag      <= '0;
        end else begin
            state        <= stateNext;
            mem_enable_o <= memEnNext;
            mem_write_o  <= memWrNext;
            mem_addr_o   <= memAddrNext;
            mem_data_o   <= memDataNext;
            missIdx      <= missIdxNext;
            missTag      <= missTagNext;
            if (refillAck) begin
                validBits[missIdx] <= 1'b1;
                dirtyBits[missIdx] <= 1'b0;
            end else if (idleHit && cpu_we_i) begin
                dirtyBits[reqIdx] <= 1'b1;
            end
        end
    end

    // Line and tag storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (refillAck) begin
            dataArr[missIdx] <= mem_data_i;
            tagArr[missIdx]  <= missTag;
        end else if (idleHit && cpu_we_i) begin
            dataArr[reqIdx][wordOff +: 32] <= cpu_data_i;
        end
    end

`ifdef DCACHE_PERF_EN
    // The held request completing right after REFILL_DONE was already counted as a miss.
    logic replay;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            replay     <= 1'b0;
        end else begin
            replay <= (state == REFILL_DONE);
            if (idleHit && !replay)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (idleMiss)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a transaction-level cache/memory model.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_PERF_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_W(4), .LINE_W(256)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_PERF_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: backing memory keyed by line address plus one cached line per set.
    logic [255:0] mainMem [int unsigned];
    logic         mValid [16];
    logic         mDirty [16];
    logic [22:0]  mTag   [16];
    logic [255:0] mLine  [16];
    int           mHits = 0;
    int           mMisses = 0;

    function automatic logic [255:0] memLine(input logic [31:0] la);
        logic [255:0] l;
        if (mainMem.exists(la)) return mainMem[la];
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = la ^ (32'(w) << 2) ^ 32'h5A00_0000;
        return l;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
        end
        mHits   = 0;
        mMisses = 0;
    endtask

    task automatic doAccess(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int lat, input int wbLat);
        logic [3:0]   idx;
        logic [22:0]  tag;
        logic [2:0]   word;
        logic         hit;
        logic [31:0]  phAddr [2];
        logic         phWr   [2];
        logic [255:0] phData [2];
        int           phLat  [2];
        int           nPh, ph, enCnt, cyc, stallCnt, expStall;
        logic         done;
        logic [31:0]  expWord;
        idx  = addr[8:5];
        tag  = addr[31:9];
        word = addr[4:2];
        hit  = mValid[idx] && (mTag[idx] == tag);
        nPh  = 0;
        if (!hit) begin
            if (mValid[idx] && mDirty[idx]) begin
                phWr[0]   = 1'b1;
                phAddr[0] = {mTag[idx], idx, 5'b0};
                phData[0] = mLine[idx];
                phLat[0]  = wbLat;
                nPh = 1;
            end
            phWr[nPh]   = 1'b0;
            phAddr[nPh] = {tag, idx, 5'b0};
            phData[nPh] = '0;
            phLat[nPh]  = lat;
            nPh++;
            mainMem[{mTag[idx], idx, 5'b0}] = (nPh == 2) ? mLine[idx] : memLine({mTag[idx], idx, 5'b0});
            mLine[idx]  = memLine({tag, idx, 5'b0});
            mValid[idx] = 1'b1;
            mTag[idx]   = tag;
            mDirty[idx] = 1'b0;
            mMisses++;
        end else begin
            mHits++;
        end
        expStall = hit ? 0 : ((nPh == 2) ? wbLat : 0) + lat + 2;
        expWord  = mLine[idx][{word, 5'b0} +: 32];
        if (we) begin
            mLine[idx][{word, 5'b0} +: 32] = wd;
            mDirty[idx] = 1'b1;
        end

        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = wd;
        mem_ack_i  = 1'b0;
        cyc = 0; stallCnt = 0; ph = 0; enCnt = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            if (cyc > 0) begin
                @(negedge clk);
                mem_ack_i = 1'b0;
            end
            #1;
            if (cyc == 0) checkVal("stallFirst", 256'(cpu_stall_o), 256'(!hit));
            if (!cpu_stall_o) begin
                done = 1'b1;
            end else begin
                stallCnt++;
                if (mem_enable_o) begin
                    if (ph >= nPh) begin
                        checkVal("unexpMem", 256'(mem_enable_o), 256'(0));
                    end else begin
                        checkVal("memWrite", 256'(mem_write_o), 256'(phWr[ph]));
                        checkVal("memAddr", 256'(mem_addr_o), 256'(phAddr[ph]));
                        if (phWr[ph] && enCnt == 0) checkVal("wbData", mem_data_o, phData[ph]);
                        enCnt++;
                        if (enCnt >= phLat[ph]) begin
                            mem_ack_i  = 1'b1;
                            mem_data_i = phWr[ph] ? {8{32'($urandom)}} : memLine(phAddr[ph]);
                            ph++;
                            enCnt = 0;
                        end
                    end
                end
            end
            cyc++;
        end
        if (!done) begin
            checkVal("timeout", 256'(0), 256'(1));
            return;
        end
        checkVal("stallCycles", 256'(stallCnt), 256'(expStall));
        checkVal("phases", 256'(ph), 256'(nPh));
        checkVal("enIdle", 256'(mem_enable_o), 256'(0));
        if (!we) checkVal("loadData", 256'(cpu_data_o), 256'(expWord));
    endtask

    task automatic idleCycle();
        @(negedge clk);
        cpu_req_i = 1'b0;
        mem_ack_i = 1'b0;
        #1;
        checkVal("idleStall", 256'(cpu_stall_o), 256'(0));
        checkVal("idleEn", 256'(mem_enable_o), 256'(0));
    endtask

    logic [22:0] tagTab [4];
    logic [255:0] seedLine;

    initial begin
        tagTab[0] = 23'h0;
        tagTab[1] = 23'h1;
        tagTab[2] = 23'h400000;
        tagTab[3] = 23'h2A5A5;
        modelReset();
        rst_i = 1'b1;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40; cpu_data_i = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        #1;
        checkVal("rstStall", 256'(cpu_stall_o), 256'(0));
        checkVal("rstEn", 256'(mem_enable_o), 256'(0));
        checkVal("rstWr", 256'(mem_write_o), 256'(0));
        checkVal("rstAddr", 256'(mem_addr_o), 256'(0));
        checkVal("rstData", mem_data_o, 256'(0));
        checkVal("rstCpuData", 256'(cpu_data_o), 256'(0));
        repeat (2) @(negedge clk);
        cpu_req_i = 1'b0;
        rst_i = 1'b0;

        seedLine = memLine(32'h40);
        seedLine[95:64] = 32'hDEADBEEF;
        mainMem[32'h40] = seedLine;
        doAccess(1'b0, 32'h48, 32'h0, 3, 1);
        checkVal("tp1Word", 256'(cpu_data_o), 256'(32'hDEADBEEF));
        doAccess(1'b0, 32'h48, 32'h0, 3, 1);
        doAccess(1'b1, 32'h44, 32'h12345678, 1, 1);
        doAccess(1'b0, 32'h244, 32'h0, 2, 3);
        checkVal("tp3Victim", 256'(mainMem[32'h40][63:32]), 256'(32'h12345678));
        doAccess(1'b1, 32'h80, 32'hCAFEF00D, 2, 1);
        doAccess(1'b0, 32'h80, 32'h0, 2, 1);
        doAccess(1'b0, 32'h280, 32'h0, 2, 2);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = {tagTab[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 4) == 0) idleCycle();
            doAccess(1'($urandom), a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
        end

        doAccess(1'b0, 32'h40, 32'h0, 1, 1);
        doAccess(1'b0, 32'h3020, 32'h0, 1, 1);
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h3220;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (mem_enable_o && !mem_write_o) break;
            @(negedge clk);
        end
        checkVal("rfEnable", 256'(mem_enable_o), 256'(1));
        checkVal("rfAddr", 256'(mem_addr_o), 256'(32'h3220));
        rst_i = 1'b1;
        #1;
        checkVal("midRstEn", 256'(mem_enable_o), 256'(0));
        checkVal("midRstStall", 256'(cpu_stall_o), 256'(0));
        cpu_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        modelReset();
        doAccess(1'b0, 32'h40, 32'h0, 2, 1);
        doAccess(1'b0, 32'h4C, 32'h0, 2, 1);
        doAccess(1'b1, 32'h3220, 32'h600DF00D, 3, 1);
        doAccess(1'b0, 32'h3220, 32'h0, 1, 1);
        doAccess(1'b1, 32'h40, 32'h0BADC0DE, 1, 1);
        idleCycle();
`ifdef DCACHE_PERF_EN
        checkVal("hitCnt", 256'(hit_cnt_o), 256'(mHits));
        checkVal("missCnt", 256'(miss_cnt_o), 256'(mMisses));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
